// File: rtl/eviction_buffer.sv
// Write-back victim queue: evicted dirty lines are drained to pmem in FIFO order and stay visible to refill lookups.
// Optional write coalescing is enabled by defining EVICTION_BUFFER_COALESCE_EN.
module eviction_buffer #(
  parameter int S_OFFSET = 5,
  parameter int S_LINE   = 256,
  parameter int DEPTH    = 4,
  parameter int S_CNT    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evict_valid,
  output logic              evict_ready,
  input  logic [31:0]       evict_addr,
  input  logic [S_LINE-1:0] evict_data,
  input  logic [31:0]       lookup_addr,
  output logic              lookup_hit,
  output logic [S_LINE-1:0] lookup_data,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [S_LINE-1:0] pmem_wdata,
  input  logic              pmem_resp,
  output logic [S_CNT-1:0]  count,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LA_W  = 32 - S_OFFSET;

  typedef enum logic {IDLE, WRITE} state_t;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [LA_W-1:0]   addr_q [DEPTH];
  logic [LA_W-1:0]   addr_d [DEPTH];
  logic [S_LINE-1:0] data_q [DEPTH];
  logic [S_LINE-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [S_CNT-1:0]  count_q, count_d;
  state_t            state_q, state_d;

  logic [LA_W-1:0]   evict_la, lookup_la;
  logic              push, alloc, pop;
  logic              coal_hit;
  logic [PTR_W-1:0]  coal_idx;

  assign evict_la  = evict_addr[31:S_OFFSET];
  assign lookup_la = lookup_addr[31:S_OFFSET];

  assign count = count_q;
  assign full  = (count_q == S_CNT'(DEPTH));
  assign empty = (count_q == '0);

`ifdef EVICTION_BUFFER_COALESCE_EN
  // The head being written cannot be modified, so it is excluded from the match.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[head_q + PTR_W'(i)] && addr_q[head_q + PTR_W'(i)] == evict_la &&
          !(state_q == WRITE && PTR_W'(i) == '0)) begin
        coal_hit = 1'b1;
        coal_idx = head_q + PTR_W'(i);
      end
    end
  end
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  assign evict_ready = !full || coal_hit;
  assign push        = evict_valid && evict_ready;
  assign alloc       = push && !coal_hit;
  assign pop         = (state_q == WRITE) && pmem_resp;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (alloc) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = evict_la;
      data_d[tail_q]  = evict_data;
      tail_d          = tail_q + PTR_W'(1);
    end else if (push) begin
      data_d[coal_idx] = evict_data;
    end
    case ({alloc, pop})
      2'b10:   count_d = count_q + S_CNT'(1);
      2'b01:   count_d = count_q - S_CNT'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pmem_write   = 1'b0;
    pmem_address = {addr_q[head_q], {S_OFFSET{1'b0}}};
    pmem_wdata   = data_q[head_q];
    case (state_q)
      IDLE: if (!empty) state_d = WRITE;
      WRITE: begin
        pmem_write = 1'b1;
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[head_q + PTR_W'(i)] && addr_q[head_q + PTR_W'(i)] == lookup_la) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[head_q + PTR_W'(i)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_eviction_buffer.sv
// Directed bench for eviction_buffer: reset, single line, fill/drain order, duplicates, full+pop, async reset.
module tb_eviction_buffer;
  logic         clk = 1'b0;
  logic         rst;
  logic         evict_valid;
  logic         evict_ready;
  logic [31:0]  evict_addr;
  logic [255:0] evict_data;
  logic [31:0]  lookup_addr;
  logic         lookup_hit;
  logic [255:0] lookup_data;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [2:0]   count;
  logic         full;
  logic         empty;

  int checks   = 0;
  int failures = 0;

  eviction_buffer dut (
    .clk(clk), .rst(rst),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_addr(evict_addr), .evict_data(evict_data),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; evict_valid = 1'b0; evict_addr = '0; evict_data = '0;
    lookup_addr = '0; pmem_resp = 1'b0;
    tick(); tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (evict_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", evict_ready); end
    checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL reset_pmem_write got=%b exp=0", pmem_write); end
    checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL reset_lookup_hit got=%b exp=0", lookup_hit); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_push();
    logic [255:0] d;
    d = {32{8'hA5}};
    evict_valid = 1'b1; evict_addr = 32'h0000_1040; evict_data = d;
    lookup_addr = 32'h0000_105F;
    #1;
    checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL single_hit_before got=%b exp=0", lookup_hit); end
    tick();
    evict_valid = 1'b0;
    #1;
    checks++; if (lookup_hit !== 1'b1) begin failures++; $display("FAIL single_hit got=%b exp=1", lookup_hit); end
    checks++; if (lookup_data !== d) begin failures++; $display("FAIL single_lookup_data got=%h exp=%h", lookup_data, d); end
    checks++; if (count !== 3'd1 || empty !== 1'b0) begin failures++; $display("FAIL single_count got=%0d/%b exp=1/0", count, empty); end
    checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL single_write_early got=%b exp=0", pmem_write); end
    tick();
    checks++; if (pmem_write !== 1'b1) begin failures++; $display("FAIL single_write got=%b exp=1", pmem_write); end
    checks++; if (pmem_address !== 32'h0000_1040) begin failures++; $display("FAIL single_addr got=%h exp=00001040", pmem_address); end
    checks++; if (pmem_wdata !== d) begin failures++; $display("FAIL single_wdata got=%h exp=%h", pmem_wdata, d); end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin failures++; $display("FAIL single_pop_count got=%0d exp=0", count); end
    checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL single_pop_hit got=%b exp=0", lookup_hit); end
    checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL single_pop_write got=%b exp=0", pmem_write); end
    tick();
  endtask

  task automatic fill_four();
    for (int i = 0; i < 4; i++) begin
      evict_valid = 1'b1;
      evict_addr  = 32'(256 * (i + 1));
      evict_data  = {8{32'(256 * (i + 1))}};
      tick();
    end
    evict_valid = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [31:0] ea;
    fill_four();
    evict_valid = 1'b1; evict_addr = 32'h500; evict_data = {8{32'h500}};
    #1;
    checks++; if (full !== 1'b1 || count !== 3'd4) begin failures++; $display("FAIL fill_full got=%b/%0d exp=1/4", full, count); end
    checks++; if (evict_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", evict_ready); end
    tick();
    evict_valid = 1'b0; lookup_addr = 32'h500;
    #1;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_fifth_count got=%0d exp=4", count); end
    checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL fill_fifth_hit got=%b exp=0", lookup_hit); end
    for (int k = 0; k < 4; k++) begin
      ea = 32'(256 * (k + 1));
      checks++; if (pmem_write !== 1'b1) begin failures++; $display("FAIL drain_write[%0d] got=%b exp=1", k, pmem_write); end
      checks++; if (pmem_address !== ea) begin failures++; $display("FAIL drain_addr[%0d] got=%h exp=%h", k, pmem_address, ea); end
      checks++; if (pmem_wdata !== {8{ea}}) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", k, pmem_wdata, {8{ea}}); end
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      #1;
      checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL drain_idle[%0d] got=%b exp=0", k, pmem_write); end
      checks++; if (count !== 3'(3 - k)) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", k, count, 3 - k); end
      tick();
    end
    checks++; if (pmem_write !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL drain_end got=%b/%b exp=0/1", pmem_write, empty); end
  endtask

  task automatic test_full_pop_push();
    logic [31:0] ea;
    fill_four();
    evict_valid = 1'b1; evict_addr = 32'h500; evict_data = {8{32'h500}}; pmem_resp = 1'b1;
    #1;
    checks++; if (evict_ready !== 1'b0) begin failures++; $display("FAIL fpp_ready_pop got=%b exp=0", evict_ready); end
    tick();
    pmem_resp = 1'b0;
    #1;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL fpp_count_pop got=%0d exp=3", count); end
    checks++; if (evict_ready !== 1'b1) begin failures++; $display("FAIL fpp_ready_next got=%b exp=1", evict_ready); end
    tick();
    evict_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fpp_count_push got=%0d exp=4", count); end
    for (int k = 0; k < 4; k++) begin
      ea = 32'(256 * (k + 2));
      checks++; if (pmem_write !== 1'b1 || pmem_address !== ea) begin failures++; $display("FAIL fpp_drain[%0d] got=%b/%h exp=1/%h", k, pmem_write, pmem_address, ea); end
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      tick();
    end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL fpp_end_count got=%0d exp=0", count); end
  endtask

`ifdef EVICTION_BUFFER_COALESCE_EN
  task automatic test_duplicate();
    logic [255:0] d0, d1, d2, d3;
    d0 = {8{32'h0000_0A0A}}; d1 = {8{32'h1111_1111}}; d2 = {8{32'h2222_2222}}; d3 = {8{32'h0B0B_0B0B}};
    evict_valid = 1'b1; evict_addr = 32'h100; evict_data = d0;
    tick();
    evict_valid = 1'b0;
    tick();
    evict_valid = 1'b1; evict_addr = 32'h200; evict_data = d1;
    tick();
    evict_data = d2;
    tick();
    evict_valid = 1'b0; lookup_addr = 32'h200;
    #1;
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL coal_count got=%0d exp=2", count); end
    checks++; if (lookup_data !== d2) begin failures++; $display("FAIL coal_lookup got=%h exp=%h", lookup_data, d2); end
    evict_valid = 1'b1; evict_addr = 32'h100; evict_data = d3;
    tick();
    evict_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL coal_head_alloc got=%0d exp=3", count); end
    checks++; if (pmem_wdata !== d0) begin failures++; $display("FAIL coal_head_data got=%h exp=%h", pmem_wdata, d0); end
    pmem_resp = 1'b1; tick(); pmem_resp = 1'b0; tick();
    checks++; if (pmem_address !== 32'h200 || pmem_wdata !== d2) begin failures++; $display("FAIL coal_w1 got=%h/%h exp=200/%h", pmem_address, pmem_wdata, d2); end
    pmem_resp = 1'b1; tick(); pmem_resp = 1'b0; tick();
    checks++; if (pmem_address !== 32'h100 || pmem_wdata !== d3) begin failures++; $display("FAIL coal_w2 got=%h/%h exp=100/%h", pmem_address, pmem_wdata, d3); end
    pmem_resp = 1'b1; tick(); pmem_resp = 1'b0; tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL coal_end got=%0d exp=0", count); end
  endtask
`else
  task automatic test_duplicate();
    logic [255:0] d1, d2;
    d1 = {8{32'h1111_1111}}; d2 = {8{32'h2222_2222}};
    evict_valid = 1'b1; evict_addr = 32'h200; evict_data = d1;
    tick();
    evict_data = d2;
    tick();
    evict_valid = 1'b0; lookup_addr = 32'h200;
    #1;
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL dup_count got=%0d exp=2", count); end
    checks++; if (lookup_data !== d2) begin failures++; $display("FAIL dup_lookup got=%h exp=%h", lookup_data, d2); end
    checks++; if (pmem_write !== 1'b1 || pmem_wdata !== d1) begin failures++; $display("FAIL dup_first got=%b/%h exp=1/%h", pmem_write, pmem_wdata, d1); end
    pmem_resp = 1'b1; tick(); pmem_resp = 1'b0;
    #1;
    checks++; if (count !== 3'd1 || lookup_data !== d2) begin failures++; $display("FAIL dup_after_pop got=%0d/%h exp=1/%h", count, lookup_data, d2); end
    tick();
    checks++; if (pmem_write !== 1'b1 || pmem_wdata !== d2) begin failures++; $display("FAIL dup_second got=%b/%h exp=1/%h", pmem_write, pmem_wdata, d2); end
    pmem_resp = 1'b1; tick(); pmem_resp = 1'b0; tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL dup_end got=%0d exp=0", count); end
  endtask
`endif

  task automatic test_reset_mid_write();
    int seen;
    for (int i = 0; i < 3; i++) begin
      evict_valid = 1'b1;
      evict_addr  = 32'(256 * (i + 1));
      evict_data  = {8{32'hC0DE_0000 + 32'(i)}};
      tick();
    end
    evict_valid = 1'b0; lookup_addr = 32'h200;
    #1;
    checks++; if (pmem_write !== 1'b1 || count !== 3'd3) begin failures++; $display("FAIL rstw_pre got=%b/%0d exp=1/3", pmem_write, count); end
    #1 rst = 1'b0;
    #1;
    checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL rstw_write got=%b exp=0", pmem_write); end
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin failures++; $display("FAIL rstw_count got=%0d/%b exp=0/1", count, empty); end
    checks++; if (lookup_hit !== 1'b0) begin failures++; $display("FAIL rstw_hit got=%b exp=0", lookup_hit); end
    tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pmem_write === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rstw_no_write got=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_drain();
    test_full_pop_push();
    test_duplicate();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
